// File: rtl/if_id_stage.sv
// IF/ID pipeline register: two-entry skid buffer (main + skid) between fetch and decode.
// The main entry drives decode with the instruction fields pre-split.
module if_id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] out_instr,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [5:0]  out_funct,
  output logic [15:0] out_imm16,
  output logic [25:0] out_jtarget,
  output logic        out_is_nop
);

  logic        main_valid_r, skid_valid_r;
  logic [31:0] main_pc_r, main_pc4_r, main_instr_r;
  logic [31:0] skid_pc_r, skid_instr_r;

  logic accept_s, xfer_s;
  logic main_valid_nxt_s, skid_valid_nxt_s;
  logic main_load_in_s, main_load_skid_s, skid_load_s;

  assign accept_s = in_valid && !skid_valid_r;
  assign xfer_s   = main_valid_r && out_ready;

  // Next-state selection; flush overrides any accept or refill.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    main_load_in_s   = 1'b0;
    main_load_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (!main_valid_r || (xfer_s && !skid_valid_r)) begin
      main_valid_nxt_s = accept_s;
      main_load_in_s   = accept_s;
    end else if (xfer_s) begin
      main_valid_nxt_s = 1'b1;
      main_load_skid_s = 1'b1;
      skid_valid_nxt_s = accept_s;
      skid_load_s      = accept_s;
    end else if (accept_s) begin
      skid_valid_nxt_s = 1'b1;
      skid_load_s      = 1'b1;
    end else begin
      main_valid_nxt_s = main_valid_r;
      skid_valid_nxt_s = skid_valid_r;
    end
  end

  // Valid flags and data registers; data only moves when its entry is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_pc_r    <= PC_RESET;
      main_pc4_r   <= PC_RESET + 32'd4;
      main_instr_r <= 32'd0;
      skid_pc_r    <= PC_RESET;
      skid_instr_r <= 32'd0;
    end else begin
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      if (main_load_in_s) begin
        main_pc_r    <= in_pc;
        main_pc4_r   <= in_pc + 32'd4;
        main_instr_r <= in_instr;
      end else if (main_load_skid_s) begin
        main_pc_r    <= skid_pc_r;
        main_pc4_r   <= skid_pc_r + 32'd4;
        main_instr_r <= skid_instr_r;
      end
      if (skid_load_s) begin
        skid_pc_r    <= in_pc;
        skid_instr_r <= in_instr;
      end
    end
  end

  assign in_ready     = !skid_valid_r;
  assign out_valid    = main_valid_r;
  assign out_pc       = main_pc_r;
  assign out_pc_plus4 = main_pc4_r;
  assign out_instr    = main_instr_r;
  assign out_opcode   = main_instr_r[31:26];
  assign out_rs       = main_instr_r[25:21];
  assign out_rt       = main_instr_r[20:16];
  assign out_rd       = main_instr_r[15:11];
  assign out_shamt    = main_instr_r[10:6];
  assign out_funct    = main_instr_r[5:0];
  assign out_imm16    = main_instr_r[15:0];
  assign out_jtarget  = main_instr_r[25:0];
  assign out_is_nop   = (main_instr_r == 32'd0);

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the stage is modelled as an in-order queue of at most
// two accepted entries; directed scenarios are followed by a randomized run.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = 32'd0;
  logic [31:0] in_instr = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_pc_plus4, out_instr;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm16;
  logic [25:0] out_jtarget;
  logic        out_is_nop;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  logic [63:0] exp_q[$];

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
    .out_jtarget(out_jtarget), .out_is_nop(out_is_nop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // MIPS field split computed arithmetically from the word
  function automatic logic [74:0] fields_of(input logic [31:0] w);
    logic [31:0] op, rs, rt, rd, sh, fn, imm, jt;
    logic nop;
    op  = w / 32'd67108864;
    rs  = (w / 32'd2097152) % 32'd32;
    rt  = (w / 32'd65536) % 32'd32;
    rd  = (w / 32'd2048) % 32'd32;
    sh  = (w / 32'd64) % 32'd32;
    fn  = w % 32'd64;
    imm = w % 32'd65536;
    jt  = w % 32'd67108864;
    nop = (w == 32'd0);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0], imm[15:0], jt[25:0], nop};
  endfunction

  // Monitor: occupancy-derived handshake checks, head-of-queue compare, pop on transfer
  always begin
    @(negedge clk);
    #1;
    if (mon_en && rst_n) begin
      int n;
      logic [63:0] h;
      logic [31:0] epc, eplus4;
      n = exp_q.size();
      chk("out_valid", out_valid, n > 0);
      chk("in_ready", in_ready, n < 2);
      if (out_valid) begin
        if (n == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got pc %h with no entry expected", out_pc);
        end else begin
          h = exp_q[0];
          epc = h[63:32];
          eplus4 = epc + 32'd4;
          chk("out_pc", out_pc, epc);
          chk("out_pc_plus4", out_pc_plus4, eplus4);
          chk("out_instr", out_instr, h[31:0]);
          chk("fields", {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
                         out_imm16, out_jtarget, out_is_nop}, fields_of(h[31:0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
    end
  end

  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    #2;
    if (v && in_ready && !fl) exp_q.push_back({pc, ins});
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'd0, 32'd0, ordy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_pc_plus4", out_pc_plus4, 32'h4);
    chk("rst_out_is_nop", out_is_nop, 1'b1);
    chk("rst_out_instr", out_instr, 32'h0);
    mon_en = 1'b1;

    // single addiu entry
    cycle(1'b1, 32'h0040_0000, 32'h2408_FFFF, 1'b1, 1'b0);
    idle(1'b1);
    chk("single_valid", out_valid, 1'b1);
    chk("single_opcode", out_opcode, 6'h09);
    chk("single_rs", out_rs, 5'd0);
    chk("single_rt", out_rt, 5'd8);
    chk("single_imm16", out_imm16, 16'hFFFF);
    chk("single_pc_plus4", out_pc_plus4, 32'h0040_0004);

    // back-pressure: A then B held, then drained one per cycle
    cycle(1'b1, 32'h10, 32'h0000_0020, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, 32'h0000_0024, 1'b0, 1'b0);
    idle(1'b0);
    chk("bp_in_ready_full", in_ready, 1'b0);
    chk("bp_shows_a", out_pc, 32'h10);
    idle(1'b1);
    chk("bp_a_out", out_pc, 32'h10);
    idle(1'b1);
    chk("bp_b_out", out_pc, 32'h14);
    chk("bp_in_ready_back", in_ready, 1'b1);
    idle(1'b0);
    chk("bp_drained", out_valid, 1'b0);

    // streaming 8 entries
    for (int i = 0; i < 9; i++) begin
      cycle(i < 8, 32'h100 + 32'(4 * i), 32'h0123_0000 + 32'(i), 1'b1, 1'b0);
      chk("stream_in_ready", in_ready, 1'b1);
      if (i > 0) begin
        chk("stream_valid", out_valid, 1'b1);
        chk("stream_pc", out_pc, 32'h100 + 32'(4 * (i - 1)));
      end
    end
    idle(1'b1);
    chk("stream_done", out_valid, 1'b0);

    // flush with main + skid full and a third entry offered
    cycle(1'b1, 32'h200, 32'hAAAA_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'h204, 32'hAAAA_0002, 1'b0, 1'b0);
    cycle(1'b1, 32'h208, 32'hAAAA_0003, 1'b0, 1'b1);
    idle(1'b1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("flush_stays_empty", out_valid, 1'b0);
    end

    // pc wrap with jal
    cycle(1'b1, 32'hFFFF_FFFC, 32'h0C00_0010, 1'b0, 1'b0);
    idle(1'b1);
    chk("wrap_pc_plus4", out_pc_plus4, 32'h0);
    chk("wrap_opcode", out_opcode, 6'h03);
    chk("wrap_jtarget", out_jtarget, 26'h10);

    // asynchronous reset with both entries full; first accept afterwards lands in main
    cycle(1'b1, 32'h300, 32'h1111_1111, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, 32'h2222_2222, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_nop", out_is_nop, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h400, 32'h3333_3333, 1'b0, 1'b0);
    idle(1'b0);
    chk("post_rst_main", out_pc, 32'h400);
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] ins;
      ins = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      cycle($urandom_range(0, 9) < 7, $urandom, ins,
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline register between instruction fetch and decode in the MIPS core.
- Accepts fetched {pc, instr} over a valid/ready handshake and buffers it in a two-entry skid buffer (main + skid).
- Presents the held instruction with its fields pre-split: opcode feeds the extension-mode decoder, imm16 feeds the immediate extender, and rs/rt/rd feed the register file.
- Supports back-pressure from decode and a flush for branch/jump redirect.

Parameters:
- PC_RESET, 32'h0000_0000, value loaded into the pc/pc_plus4 data registers on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered entries; highest priority.
- in_valid  in  1  fetch presents a valid entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_pc  in  32  address of the fetched instruction.
- in_instr  in  32  fetched instruction word.
- out_valid  out  1  decode-side entry is valid.
- out_ready  in  1  decode consumes the entry this cycle.
- out_pc  out  32  pc of the held entry.
- out_pc_plus4  out  32  out_pc + 4.
- out_instr  out  32  held instruction word.
- out_opcode  out  6  instr[31:26].
- out_rs  out  5  instr[25:21].
- out_rt  out  5  instr[20:16].
- out_rd  out  5  instr[15:11].
- out_shamt  out  5  instr[10:6].
- out_funct  out  6  instr[5:0].
- out_imm16  out  16  instr[15:0].
- out_jtarget  out  26  instr[25:0].
- out_is_nop  out  1  held instr == 32'h0.

Behaviour:
- State:
  - main entry {main_valid, pc, instr} drives all out_* ports.
  - skid entry {skid_valid, pc, instr}.
- in_ready = !skid_valid. This is a direct register output, not combinational from out_ready.
- Accept occurs when in_valid && in_ready. Transfer to decode occurs when out_valid && out_ready.
- out_valid = main_valid.
- Per-cycle update when flush=0:
  - main empty, or main transferring with skid empty: on accept, main ← input; with no accept, main_valid ← 0 if it transferred, otherwise unchanged.
  - Main transferring with skid full: main ← skid. On accept, skid ← input; otherwise skid_valid ← 0.
  - Main full and not transferring: on accept, skid ← input (reachable only when skid is empty).
- Ordering: entries reach decode in accept order. No entry is duplicated or dropped except by flush.
- Flush:
  - Next cycle, main_valid = skid_valid = 0.
  - An input accepted in the flush cycle is discarded.
  - A transfer in the flush cycle is still considered consumed by decode.
  - in_ready = 1 in the cycle after flush.
- Latency: an entry accepted into an empty stage appears at out_valid on the next edge (1 cycle).
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Field decode is combinational from the main data register. out_pc_plus4 = out_pc + 32'd4, modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000).
- Data registers load only when their entry is written; they hold their value while invalid.
- Reset (rst_n=0, asynchronous):
  - main_valid = skid_valid = 0, so out_valid=0 and in_ready=1.
  - instr regs = 0, so out_is_nop=1 and all fields are 0.
  - pc regs = PC_RESET, so out_pc_plus4 = PC_RESET + 4.
- Reset deassertion mid-transfer: entries present before reset are lost. The first accept after release lands in main.
- Simultaneous flush and reset: reset wins.

Test Plan:
- Reset: hold rst_n=0, then release → out_valid=0, in_ready=1, out_pc=0, out_pc_plus4=4, out_is_nop=1.
- Single entry: in_pc=32'h0040_0000, in_instr=32'h2408_FFFF (addiu), out_ready=1 → next cycle out_valid=1, opcode=6'h09, rs=0, rt=8, imm16=16'hFFFF, out_pc_plus4=32'h0040_0004.
- Back-pressure: out_ready=0 while sending A(pc=0x10) then B(pc=0x14):
  - After the 2nd accept, in_ready=0 and out shows A.
  - Raise out_ready → A, then B, one per cycle.
  - in_ready returns to 1 the cycle after A transfers.
- Streaming: 8 back-to-back entries with pcs 0x100..0x11C and out_ready=1 → 8 consecutive out_valid cycles in order; in_ready stays 1.
- Flush: with both main and skid full and a new in_valid in the same cycle, assert flush for one cycle → next cycle out_valid=0, in_ready=1; none of the three entries ever reappears.
- Wrap: in_pc=32'hFFFF_FFFC, in_instr=32'h0C00_0010 (jal) → out_pc_plus4=32'h0, out_opcode=6'h03, out_jtarget=26'h10.
